// File: rtl/cipher_pkg.sv
// -----------------------------------------------------------------------------
// cipher_pkg
// Shared constants, types and helpers for the Vigenere stream cipher.
//   ALPHA_N        : letters in the alphabet (modulus of the shift)
//   ASCII_UPPER_A  : 'A'
//   ASCII_LOWER_A  : 'a'
//   cipher_state_t : message FSM states (IDLE between messages, RUN inside one)
//   byte_class_t   : letter classification of a byte
//   classify_byte  : upper / lower / other classification
//   key_offset     : shift amount for a key byte ('A'..'Z' -> 0..25, else 0)
// -----------------------------------------------------------------------------
package cipher_pkg;

    localparam int         ALPHA_N       = 26;
    localparam logic [7:0] ASCII_UPPER_A = 8'h41;
    localparam logic [7:0] ASCII_LOWER_A = 8'h61;
    localparam logic [7:0] ASCII_UPPER_Z = 8'h5A;
    localparam logic [7:0] ASCII_LOWER_Z = 8'h7A;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } cipher_state_t;

    typedef enum logic [1:0] {
        CLS_OTHER = 2'd0,
        CLS_UPPER = 2'd1,
        CLS_LOWER = 2'd2
    } byte_class_t;

    function automatic byte_class_t classify_byte(input logic [7:0] b);
        byte_class_t cls;
        cls = CLS_OTHER;
        if (b >= ASCII_UPPER_A && b <= ASCII_UPPER_Z) begin
            cls = CLS_UPPER;
        end else if (b >= ASCII_LOWER_A && b <= ASCII_LOWER_Z) begin
            cls = CLS_LOWER;
        end
        return cls;
    endfunction

    // Key bytes are expected to be uppercase; anything else means "no shift".
    function automatic logic [4:0] key_offset(input logic [7:0] k);
        logic [4:0] off;
        off = 5'd0;
        if (k >= ASCII_UPPER_A && k <= ASCII_UPPER_Z) begin
            off = 5'(k - ASCII_UPPER_A);
        end
        return off;
    endfunction

endpackage

// File: rtl/vigenere_shift.sv
// -----------------------------------------------------------------------------
// vigenere_shift
// Combinational single-byte Vigenere shift. Letters are rotated within their
// own case range; every other byte is returned unchanged.
// Ports:
//   byte_in  [7:0] : byte to transform
//   offset   [4:0] : key offset 0..25
//   dec            : 0 = shift forward (encrypt), 1 = shift backward (decrypt)
//   byte_out [7:0] : transformed byte
// -----------------------------------------------------------------------------
module vigenere_shift
    import cipher_pkg::*;
(
    input  logic [7:0] byte_in,
    input  logic [4:0] offset,
    input  logic       dec,
    output logic [7:0] byte_out
);

    byte_class_t cls;
    logic [7:0]  base;
    logic [5:0]  pos;
    logic [5:0]  sum;
    logic [5:0]  wrapped;

    always_comb begin
        cls  = classify_byte(byte_in);
        base = (cls == CLS_UPPER) ? ASCII_UPPER_A : ASCII_LOWER_A;
        pos  = 6'(byte_in - base);
        // Decrypt adds ALPHA_N first so the subtraction never goes negative;
        // sum then lies in 0..51 and a single conditional subtract is the mod.
        if (dec) begin
            sum = pos + 6'(ALPHA_N) - {1'b0, offset};
        end else begin
            sum = pos + {1'b0, offset};
        end
        wrapped = (sum >= 6'(ALPHA_N)) ? (sum - 6'(ALPHA_N)) : sum;
        if (cls == CLS_OTHER) begin
            byte_out = byte_in;
        end else begin
            byte_out = base + {2'b00, wrapped};
        end
    end

endmodule

// File: rtl/vigenere_stream_cipher.sv
// -----------------------------------------------------------------------------
// vigenere_stream_cipher
// Streaming Vigenere encrypt/decrypt, one byte per cycle, with a runtime
// loadable key of 1..KEY_MAX_LEN uppercase letters. One output register stage:
// a byte accepted on s_* appears on m_* the following cycle.
//
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   mode_dec        : 0 encrypt / 1 decrypt, captured on a message's first beat
//   key_wr_en/idx/data : key byte write port (accepted only when idle and no
//                     input handshake in the same cycle)
//   key_len         : active key length, captured on a message's first beat
//   key_err         : one-cycle pulse after a rejected key write
//   s_valid/ready/data/last : input byte stream
//   m_valid/ready/data/last : output byte stream
//   busy            : a multi-beat message is in progress
//
// Optional build macro VIGENERE_STATS_EN adds:
//   byte_cnt [31:0] : output handshakes, saturating
//   msg_cnt  [15:0] : output handshakes carrying m_last, saturating
// -----------------------------------------------------------------------------
module vigenere_stream_cipher
    import cipher_pkg::*;
#(
    parameter int KEY_MAX_LEN = 16,
    parameter int KEY_IDX_W   = $clog2(KEY_MAX_LEN)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mode_dec,
    input  logic                 key_wr_en,
    input  logic [KEY_IDX_W-1:0] key_wr_idx,
    input  logic [7:0]           key_wr_data,
    input  logic [KEY_IDX_W:0]   key_len,
    output logic                 key_err,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [7:0]           s_data,
    input  logic                 s_last,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [7:0]           m_data,
    output logic                 m_last,
    output logic                 busy
`ifdef VIGENERE_STATS_EN
    ,
    output logic [31:0]          byte_cnt,
    output logic [15:0]          msg_cnt
`endif
);

    localparam int                 LEN_W         = KEY_IDX_W + 1;
    localparam logic [KEY_IDX_W:0] KEY_LEN_LIMIT = LEN_W'(KEY_MAX_LEN);

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    cipher_state_t        state_reg, state_next;
    logic                 mode_reg, mode_next;
    logic [KEY_IDX_W:0]   len_reg, len_next;
    logic [KEY_IDX_W-1:0] idx_reg, idx_next;
    logic                 m_valid_reg, m_valid_next;
    logic [7:0]           m_data_reg, m_data_next;
    logic                 m_last_reg, m_last_next;
    logic                 key_err_reg;
    logic [7:0]           key_mem [KEY_MAX_LEN];

    // ---------------------------------------------------------------------
    // Datapath signals
    // ---------------------------------------------------------------------
    logic                 in_hs;
    logic                 eff_dec;
    logic [KEY_IDX_W:0]   eff_len;
    logic                 len_ok;
    logic                 in_letter;
    logic                 idx_at_end;
    logic [4:0]           shift_off;
    logic [7:0]           shift_out;
    logic                 key_wr_ok;

    assign s_ready = !m_valid_reg || m_ready;
    assign m_valid = m_valid_reg;
    assign m_data  = m_data_reg;
    assign m_last  = m_last_reg;
    assign key_err = key_err_reg;
    assign busy    = (state_reg == RUN);

    always_comb begin
        in_hs = s_valid && s_ready;
        // A message's first beat uses the live controls; later beats use the
        // values captured when the message started.
        eff_dec    = (state_reg == IDLE) ? mode_dec : mode_reg;
        eff_len    = (state_reg == IDLE) ? key_len  : len_reg;
        len_ok     = (eff_len != '0) && (eff_len <= KEY_LEN_LIMIT);
        in_letter  = (classify_byte(s_data) != CLS_OTHER);
        idx_at_end = ({1'b0, idx_reg} == (eff_len - LEN_W'(1)));
        shift_off  = len_ok ? key_offset(key_mem[idx_reg]) : 5'd0;
        key_wr_ok  = key_wr_en && (state_reg == IDLE) && !in_hs &&
                     ({1'b0, key_wr_idx} < KEY_LEN_LIMIT);
    end

    vigenere_shift u_shift (
        .byte_in  (s_data),
        .offset   (shift_off),
        .dec      (eff_dec),
        .byte_out (shift_out)
    );

    // ---------------------------------------------------------------------
    // Next-state logic: FSM, key index, output register
    // ---------------------------------------------------------------------
    always_comb begin
        state_next   = state_reg;
        mode_next    = mode_reg;
        len_next     = len_reg;
        idx_next     = idx_reg;
        m_valid_next = m_valid_reg;
        m_data_next  = m_data_reg;
        m_last_next  = m_last_reg;

        if (in_hs) begin
            case (state_reg)
                IDLE: begin
                    if (!s_last) begin
                        state_next = RUN;
                        mode_next  = mode_dec;
                        len_next   = key_len;
                    end
                end
                RUN: begin
                    if (s_last) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase

            // Non-letters and invalid key lengths leave the index untouched
            // (which is 0 in the invalid-length case).
            if (s_last || !len_ok) begin
                idx_next = '0;
            end else if (in_letter) begin
                idx_next = idx_at_end ? '0 : (idx_reg + KEY_IDX_W'(1));
            end

            m_valid_next = 1'b1;
            m_data_next  = shift_out;
            m_last_next  = s_last;
        end else if (m_ready) begin
            // Data/last keep their old value; only valid drops.
            m_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            mode_reg    <= 1'b0;
            len_reg     <= '0;
            idx_reg     <= '0;
            m_valid_reg <= 1'b0;
            m_data_reg  <= 8'h00;
            m_last_reg  <= 1'b0;
            key_err_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            mode_reg    <= mode_next;
            len_reg     <= len_next;
            idx_reg     <= idx_next;
            m_valid_reg <= m_valid_next;
            m_data_reg  <= m_data_next;
            m_last_reg  <= m_last_next;
            key_err_reg <= key_wr_en && !key_wr_ok;
        end
    end

    // ---------------------------------------------------------------------
    // Key storage: one register per slot, cleared to 'A' (zero shift).
    // ---------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < KEY_MAX_LEN; gi++) begin : g_key
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    key_mem[gi] <= ASCII_UPPER_A;
                end else if (key_wr_ok && (key_wr_idx == KEY_IDX_W'(gi))) begin
                    key_mem[gi] <= key_wr_data;
                end
            end
        end
    endgenerate

`ifdef VIGENERE_STATS_EN
    // ---------------------------------------------------------------------
    // Saturating output statistics
    // ---------------------------------------------------------------------
    logic        out_hs;
    logic [31:0] byte_cnt_reg;
    logic [15:0] msg_cnt_reg;

    assign out_hs   = m_valid_reg && m_ready;
    assign byte_cnt = byte_cnt_reg;
    assign msg_cnt  = msg_cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_cnt_reg <= '0;
            msg_cnt_reg  <= '0;
        end else if (out_hs) begin
            if (byte_cnt_reg != '1) begin
                byte_cnt_reg <= byte_cnt_reg + 32'd1;
            end
            if (m_last_reg && (msg_cnt_reg != '1)) begin
                msg_cnt_reg <= msg_cnt_reg + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_vigenere_stream_cipher.sv
// -----------------------------------------------------------------------------
// tb_vigenere_stream_cipher
// Directed-vector bench for vigenere_stream_cipher. Expected strings were
// worked out by hand from the shift rule (key "KEY" = offsets 10, 4, 24).
// -----------------------------------------------------------------------------
module tb_vigenere_stream_cipher;

    logic       clk = 1'b0;
    logic       rst;
    logic       mode_dec;
    logic       key_wr_en;
    logic [3:0] key_wr_idx;
    logic [7:0] key_wr_data;
    logic [4:0] key_len;
    logic       key_err;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_data;
    logic       s_last;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
    logic       m_last;
    logic       busy;

    int total = 0;
    int bad   = 0;

    logic [7:0] out_q[$];
    logic       last_q[$];

    localparam int CYC_LIMIT = 400;

    always #5 clk = ~clk;

    vigenere_stream_cipher #(.KEY_MAX_LEN(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .mode_dec    (mode_dec),
        .key_wr_en   (key_wr_en),
        .key_wr_idx  (key_wr_idx),
        .key_wr_data (key_wr_data),
        .key_len     (key_len),
        .key_err     (key_err),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .s_last      (s_last),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .m_last      (m_last),
        .busy        (busy)
    );

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_key(input string k);
        for (int i = 0; i < k.len(); i++) begin
            @(negedge clk);
            key_wr_en   = 1'b1;
            key_wr_idx  = 4'(i);
            key_wr_data = k[i];
            @(negedge clk);
            key_wr_en = 1'b0;
            #1;
            chk_val($sformatf("key_load_err%0d", i), key_err, 1'b0);
        end
    endtask

    // Drives one message cycle by cycle. Inputs change on the falling edge,
    // outputs are sampled 1 time unit later. m_ready is dropped for stall_n
    // cycles starting at cycle stall_at; flip toggles mode_dec after beat 0.
    task automatic run_msg(input string txt, input bit dec, input logic [4:0] klen,
                           input int stall_at, input int stall_n, input bit flip,
                           output int cyc);
        int         sent;
        bit         stall;
        bit         prev_stall;
        logic [7:0] held_data;
        logic       held_last;
        sent = 0;
        cyc = 0;
        prev_stall = 1'b0;
        held_data = 8'h00;
        held_last = 1'b0;
        out_q.delete();
        last_q.delete();
        forever begin
            @(negedge clk);
            if (sent == txt.len() && !m_valid) break;
            if (cyc >= CYC_LIMIT) break;
            stall   = (cyc >= stall_at) && (cyc < stall_at + stall_n);
            m_ready = !stall;
            if (sent < txt.len()) begin
                s_valid = 1'b1;
                s_data  = txt[sent];
                s_last  = (sent == txt.len() - 1);
            end else begin
                s_valid = 1'b0;
                s_data  = 8'h00;
                s_last  = 1'b0;
            end
            mode_dec = dec ^ (flip && (sent > 0));
            key_len  = klen;
            #1;
            if (m_valid && m_ready) begin
                out_q.push_back(m_data);
                last_q.push_back(m_last);
            end
            if (stall && m_valid) begin
                chk_val("stall_s_ready", s_ready, 1'b0);
                if (prev_stall) begin
                    chk_val("stall_hold_data", m_data, held_data);
                    chk_val("stall_hold_last", m_last, held_last);
                end
                held_data = m_data;
                held_last = m_last;
            end
            prev_stall = stall && m_valid;
            if (s_valid && s_ready) sent++;
            cyc++;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        m_ready = 1'b1;
        chk_val("timeout", (cyc < CYC_LIMIT), 1'b1);
    endtask

    task automatic check_out(input string tag, input string exp, input int cyc, input int exp_cyc);
        string got;
        got = "";
        for (int i = 0; i < out_q.size(); i++) got = $sformatf("%s%c", got, out_q[i]);
        $display("msg %s: out=\"%s\" want=\"%s\" cycles=%0d", tag, got, exp, cyc);
        chk_val({tag, "/len"}, out_q.size(), exp.len());
        chk_val({tag, "/cycles"}, cyc, exp_cyc);
        for (int i = 0; i < exp.len() && i < out_q.size(); i++) begin
            chk_val($sformatf("%s/byte%0d", tag, i), out_q[i], exp[i]);
            chk_val($sformatf("%s/last%0d", tag, i), last_q[i], (i == exp.len() - 1));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=running want=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        rst         = 1'b1;
        mode_dec    = 1'b0;
        key_wr_en   = 1'b0;
        key_wr_idx  = 4'd0;
        key_wr_data = 8'h00;
        key_len     = 5'd0;
        s_valid     = 1'b0;
        s_data      = 8'h00;
        s_last      = 1'b0;
        m_ready     = 1'b1;

        repeat (2) @(negedge clk);
        #1;
        chk_val("rst_m_valid", m_valid, 1'b0);
        chk_val("rst_m_data", m_data, 8'h00);
        chk_val("rst_m_last", m_last, 1'b0);
        chk_val("rst_key_err", key_err, 1'b0);
        chk_val("rst_busy", busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Default key is all 'A' -> zero shift.
        run_msg("QZ", 1'b0, 5'd2, 0, 0, 1'b0, cyc);
        check_out("default_key", "QZ", cyc, 3);

        load_key("KEY");

        run_msg("AABBCCDDEE", 1'b0, 5'd3, 0, 0, 1'b0, cyc);
        check_out("enc_key", "KEZLGANHCO", cyc, 11);

        run_msg("KEZLGANHCO", 1'b1, 5'd3, 0, 0, 1'b0, cyc);
        check_out("dec_key", "AABBCCDDEE", cyc, 11);

        run_msg("A", 1'b0, 5'd3, 0, 0, 1'b0, cyc);
        check_out("idx_reset", "K", cyc, 2);

        // b is the third letter -> offset 24 (Y): 1+24 = 25 -> 'z'.
        run_msg("A B!b", 1'b0, 5'd3, 0, 0, 1'b0, cyc);
        check_out("passthru", "K F!z", cyc, 6);

        run_msg("hello", 1'b0, 5'd3, 0, 0, 1'b0, cyc);
        check_out("lower", "rijvs", cyc, 6);

        run_msg("AABBCCDDEE", 1'b0, 5'd3, 4, 5, 1'b0, cyc);
        check_out("stall", "KEZLGANHCO", cyc, 16);

        // Mode toggled after the first beat must be ignored (latched encrypt).
        run_msg("AAA", 1'b0, 5'd3, 0, 0, 1'b1, cyc);
        check_out("mode_latch", "KEY", cyc, 4);

        run_msg("Hi, Zed", 1'b0, 5'd0, 0, 0, 1'b0, cyc);
        check_out("len0", "Hi, Zed", cyc, 8);

        run_msg("abc", 1'b0, 5'd17, 0, 0, 1'b0, cyc);
        check_out("len17", "abc", cyc, 4);

        // Key write while busy: rejected, key_err pulses once.
        @(negedge clk);
        s_valid  = 1'b1;
        s_data   = "A";
        s_last   = 1'b0;
        mode_dec = 1'b0;
        key_len  = 5'd3;
        @(negedge clk);
        s_valid     = 1'b0;
        key_wr_en   = 1'b1;
        key_wr_idx  = 4'd0;
        key_wr_data = "Z";
        #1;
        chk_val("busy_high", busy, 1'b1);
        chk_val("busy_first_out", m_data, "K");
        @(negedge clk);
        key_wr_en = 1'b0;
        #1;
        chk_val("key_err_pulse", key_err, 1'b1);
        @(negedge clk);
        #1;
        chk_val("key_err_once", key_err, 1'b0);
        run_msg("A", 1'b0, 5'd3, 0, 0, 1'b0, cyc);
        check_out("busy_cont", "E", cyc, 2);
        run_msg("A", 1'b0, 5'd3, 0, 0, 1'b0, cyc);
        check_out("key_kept", "K", cyc, 2);

        // Reset during the 4th beat of a message.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            s_valid  = 1'b1;
            s_data   = "A";
            s_last   = 1'b0;
            mode_dec = 1'b0;
            key_len  = 5'd3;
        end
        @(negedge clk);
        s_data = "A";
        #1;
        chk_val("pre_rst_busy", busy, 1'b1);
        rst = 1'b1;
        #1;
        chk_val("mid_rst_m_valid", m_valid, 1'b0);
        chk_val("mid_rst_busy", busy, 1'b0);
        @(negedge clk);
        rst     = 1'b0;
        s_valid = 1'b0;
        run_msg("Q", 1'b0, 5'd1, 0, 0, 1'b0, cyc);
        check_out("key_cleared", "Q", cyc, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
